// File: rtl/rec_play_ctrl.sv
// Record-then-play sequencer: key debounce, DDR FIFO load pulses, word counting.
// Optional: define LOOP_PLAY_EN to repeat playback until a press or DDR loss.
module rec_play_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int LOAD_CYC   = 16,
  parameter int MAX_WORDS  = 480000,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key1,
  input  logic             ddr_init_done,
  input  logic             sys_we,
  input  logic             sys_rd,
  output logic             record_en,
  output logic             play_en,
  output logic             wr_load,
  output logic             rd_load,
  output logic [CNT_W-1:0] rec_words,
  output logic             busy
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(LOAD_CYC + 1);
  localparam logic [DW-1:0] LP_DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LP_LOAD_LAST = LW'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_REC_LOAD,
    S_RECORD,
    S_PLAY_LOAD,
    S_PLAY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_key_s1;
  logic             r_key_s2;
  logic             r_key_db;
  logic             r_key_db_d;
  logic [DW-1:0]    r_deb_cnt;
  logic [LW-1:0]    r_load_cnt;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_rec_words;
  logic             r_record_en;
  logic             r_play_en;
  logic             r_wr_load;
  logic             r_rd_load;
  logic             r_busy;

  logic             w_press;
  logic             w_release;
  logic             w_load_done;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic             w_rec_exit;
  logic             w_play_done;

  // Debounced level only moves after DEB_CYCLES straight cycles of disagreement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key_s1   <= 1'b1;
      r_key_s2   <= 1'b1;
      r_key_db   <= 1'b1;
      r_key_db_d <= 1'b1;
      r_deb_cnt  <= '0;
    end else begin
      r_key_s1   <= key1;
      r_key_s2   <= r_key_s1;
      r_key_db_d <= r_key_db;
      if (r_key_s2 == r_key_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == LP_DEB_LAST) begin
        r_key_db  <= r_key_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  assign w_press     = r_key_db_d & ~r_key_db;
  assign w_release   = ~r_key_db_d & r_key_db;
  assign w_load_done = (r_load_cnt == LP_LOAD_LAST);
  assign w_wcnt_nxt  = (sys_we && r_wcnt != LP_MAX) ?
                       r_wcnt + CNT_W'(1) : r_wcnt;
  assign w_pcnt_nxt  = sys_rd ? r_pcnt + CNT_W'(1) : r_pcnt;
  assign w_rec_exit  = w_release || (w_wcnt_nxt == LP_MAX);
  assign w_play_done = (w_pcnt_nxt == r_rec_words);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_WAIT_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!ddr_init_done) begin
      w_state_nxt = S_WAIT_INIT;
    end else begin
      case (r_state)
        S_WAIT_INIT: w_state_nxt = S_IDLE;
        S_IDLE:
          if (w_press) w_state_nxt = S_REC_LOAD;
        S_REC_LOAD:
          if (w_load_done) w_state_nxt = S_RECORD;
        S_RECORD:
          if (w_rec_exit)
            w_state_nxt = (w_wcnt_nxt == '0) ? S_IDLE : S_PLAY_LOAD;
        S_PLAY_LOAD:
          if (w_load_done) w_state_nxt = S_PLAY;
        S_PLAY: begin
          if (w_press) begin
            w_state_nxt = S_REC_LOAD;
          end else if (w_play_done) begin
`ifdef LOOP_PLAY_EN
            w_state_nxt = S_PLAY_LOAD;
`else
            w_state_nxt = S_IDLE;
`endif
          end
        end
        default: w_state_nxt = S_WAIT_INIT;
      endcase
    end
  end

  // Load pulse timer runs only while sitting in a load state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_cnt  <= '0;
      r_wcnt      <= '0;
      r_pcnt      <= '0;
      r_rec_words <= '0;
    end else begin
      if (r_state == S_REC_LOAD || r_state == S_PLAY_LOAD)
        r_load_cnt <= r_load_cnt + LW'(1);
      else
        r_load_cnt <= '0;
      if (r_state == S_REC_LOAD)   r_wcnt <= '0;
      else if (r_state == S_RECORD) r_wcnt <= w_wcnt_nxt;
      if (r_state == S_PLAY_LOAD)  r_pcnt <= '0;
      else if (r_state == S_PLAY)   r_pcnt <= w_pcnt_nxt;
      if (r_state == S_RECORD && w_rec_exit && ddr_init_done)
        r_rec_words <= w_wcnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_record_en <= 1'b0;
      r_play_en   <= 1'b0;
      r_wr_load   <= 1'b0;
      r_rd_load   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_record_en <= (w_state_nxt == S_RECORD);
      r_play_en   <= (w_state_nxt == S_PLAY);
      r_wr_load   <= (w_state_nxt == S_REC_LOAD);
      r_rd_load   <= (w_state_nxt == S_PLAY_LOAD);
      r_busy      <= !(w_state_nxt == S_IDLE ||
                       w_state_nxt == S_WAIT_INIT);
    end
  end

  assign record_en = r_record_en;
  assign play_en   = r_play_en;
  assign wr_load   = r_wr_load;
  assign rd_load   = r_rd_load;
  assign rec_words = r_rec_words;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Randomized bench for rec_play_ctrl against a transaction-level model
// of recording length, load pulse widths and playback length.
module tb_rec_play_ctrl;

  localparam int DEB   = 8;
  localparam int LOADC = 4;
  localparam int MAXW  = 16;
  localparam int CW    = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key1 = 1'b1;
  logic          ddr_init_done = 1'b0;
  logic          sys_we = 1'b0;
  logic          sys_rd = 1'b0;
  logic          record_en;
  logic          play_en;
  logic          wr_load;
  logic          rd_load;
  logic [CW-1:0] rec_words;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_rec = 0;

  always #5 clk = ~clk;

  rec_play_ctrl #(
    .DEB_CYCLES(DEB),
    .LOAD_CYC(LOADC),
    .MAX_WORDS(MAXW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key1(key1),
    .ddr_init_done(ddr_init_done),
    .sys_we(sys_we),
    .sys_rd(sys_rd),
    .record_en(record_en),
    .play_en(play_en),
    .wr_load(wr_load),
    .rd_load(rd_load),
    .rec_words(rec_words),
    .busy(busy)
  );

  // Model: a recording stores every accepted strobe, capped at the limit
  function automatic int exp_rec(input int n_we);
    return (n_we > MAXW) ? MAXW : n_we;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_wait(output int cyc);
    key1 = 1'b0;
    cyc = 0;
    while (!wr_load && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_wait(output int cyc);
    key1 = 1'b1;
    cyc = 0;
    while (record_en && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  task automatic width(input bit sel_rd, output int n);
    n = 0;
    while ((sel_rd ? rd_load : wr_load) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic send_we(input int n);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 3));
      sys_we = 1'b1;
      tick();
      sys_we = 1'b0;
    end
  endtask

  task automatic send_rd(input int n, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 3));
      sys_rd = 1'b1;
      sys_we = 1'($urandom_range(0, 1));
      tick();
      sys_rd = 1'b0;
      sys_we = 1'b0;
      if (i < n - 1 && play_en !== 1'b1) early++;
    end
  endtask

  task automatic init_blip();
    ddr_init_done = 1'b0;
    tick();
    ddr_init_done = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    logic any;
    rst_n = 1'b0;
    ddr_init_done = 1'b0;
    key1 = 1'b1;
    tick(3);
    n_cmp++;
    if ({record_en, play_en, wr_load, rd_load, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 00000",
               {record_en, play_en, wr_load, rd_load, busy});
    end
    n_cmp++;
    if (rec_words !== '0) begin
      n_err++;
      $display("FAIL reset_rec_words: got %0d want 0", rec_words);
    end
    rst_n = 1'b1;
    any = 1'b0;
    key1 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) key1 = 1'b1;
      tick();
      any |= record_en | play_en | wr_load | rd_load | busy;
    end
    n_cmp++;
    if (any !== 1'b0) begin
      n_err++;
      $display("FAIL wait_init_quiet: got %b want 0", any);
    end
    ddr_init_done = 1'b1;
    tick(5);
    n_cmp++;
    if ({record_en, play_en, wr_load, rd_load, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL idle_outs: got %b want 00000",
               {record_en, play_en, wr_load, rd_load, busy});
    end
    m_rec = 0;
  endtask

  task automatic test_glitch_and_press();
    int g;
    int cyc;
    int w;
    logic seen;
    for (int k = 0; k < 3; k++) begin
      g = $urandom_range(1, DEB - 2);
      key1 = 1'b0;
      tick(g);
      key1 = 1'b1;
      seen = 1'b0;
      repeat (20) begin
        tick();
        seen |= wr_load;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_%0d_len%0d: wr_load got %b want 0", k, g, seen);
      end
    end
    press_wait(cyc);
    n_cmp++;
    if (cyc < DEB + 2 || cyc > DEB + 5) begin
      n_err++;
      $display("FAIL press_latency: got %0d want %0d..%0d",
               cyc, DEB + 2, DEB + 5);
    end
    width(1'b0, w);
    n_cmp++;
    if (w != LOADC) begin
      n_err++;
      $display("FAIL wr_load_width: got %0d want %0d", w, LOADC);
    end
    n_cmp++;
    if (record_en !== 1'b1) begin
      n_err++;
      $display("FAIL record_en_rise: got %b want 1", record_en);
    end
    release_wait(cyc);
    n_cmp++;
    if (cyc >= 60) begin
      n_err++;
      $display("FAIL release_timeout: got %0d want <60", cyc);
    end
    m_rec = 0;
    tick(3);
  endtask

  task automatic test_record_play();
    int n;
    int cyc;
    int w;
    int early;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, MAXW - 1);
      press_wait(cyc);
      n_cmp++;
      if (cyc >= 60) begin
        n_err++;
        $display("FAIL rp%0d_press: got %0d want <60", k, cyc);
      end
      width(1'b0, w);
      send_we(n);
      release_wait(cyc);
      m_rec = exp_rec(n);
      n_cmp++;
      if (rec_words !== CW'(m_rec)) begin
        n_err++;
        $display("FAIL rp%0d_rec_words: got %0d want %0d", k, rec_words, m_rec);
      end
      n_cmp++;
      if (rd_load !== 1'b1) begin
        n_err++;
        $display("FAIL rp%0d_rd_load_rise: got %b want 1", k, rd_load);
      end
      width(1'b1, w);
      n_cmp++;
      if (w != LOADC) begin
        n_err++;
        $display("FAIL rp%0d_rd_load_width: got %0d want %0d", k, w, LOADC);
      end
      n_cmp++;
      if (play_en !== 1'b1) begin
        n_err++;
        $display("FAIL rp%0d_play_en: got %b want 1", k, play_en);
      end
      send_rd(m_rec, early);
      n_cmp++;
      if (early != 0) begin
        n_err++;
        $display("FAIL rp%0d_early_stop: got %0d want 0", k, early);
      end
      n_cmp++;
      if (play_en !== 1'b0) begin
        n_err++;
        $display("FAIL rp%0d_play_end: got %b want 0", k, play_en);
      end
`ifdef LOOP_PLAY_EN
      n_cmp++;
      if (rd_load !== 1'b1) begin
        n_err++;
        $display("FAIL rp%0d_loop_reload: got %b want 1", k, rd_load);
      end
      init_blip();
`else
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL rp%0d_busy: got %b want 0", k, busy);
      end
`endif
      n_cmp++;
      if (rec_words !== CW'(m_rec)) begin
        n_err++;
        $display("FAIL rp%0d_rec_kept: got %0d want %0d", k, rec_words, m_rec);
      end
      tick(2);
    end
  endtask

  task automatic test_limit();
    int cyc;
    int w;
    int early;
    logic seen;
    press_wait(cyc);
    width(1'b0, w);
    send_we(MAXW - 1);
    n_cmp++;
    if (record_en !== 1'b1) begin
      n_err++;
      $display("FAIL lim_before: record_en got %b want 1", record_en);
    end
    send_we(1);
    m_rec = exp_rec(MAXW + 4);
    n_cmp++;
    if (record_en !== 1'b0) begin
      n_err++;
      $display("FAIL lim_stop: record_en got %b want 0", record_en);
    end
    n_cmp++;
    if (rec_words !== CW'(m_rec)) begin
      n_err++;
      $display("FAIL lim_rec_words: got %0d want %0d", rec_words, m_rec);
    end
    sys_we = 1'b1;
    width(1'b1, w);
    sys_we = 1'b0;
    n_cmp++;
    if (w != LOADC) begin
      n_err++;
      $display("FAIL lim_rd_load_width: got %0d want %0d", w, LOADC);
    end
    n_cmp++;
    if (rec_words !== CW'(m_rec)) begin
      n_err++;
      $display("FAIL lim_extra_we: got %0d want %0d", rec_words, m_rec);
    end
    send_rd(m_rec, early);
    n_cmp++;
    if (early != 0 || play_en !== 1'b0) begin
      n_err++;
      $display("FAIL lim_play: early %0d play_en %b want 0 0", early, play_en);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= wr_load;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL lim_held_key: wr_load got %b want 0", seen);
    end
    key1 = 1'b1;
    tick(20);
`ifdef LOOP_PLAY_EN
    init_blip();
`endif
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL lim_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_zero_words();
    int cyc;
    int w;
    logic seen;
    press_wait(cyc);
    width(1'b0, w);
    n_cmp++;
    if (w != LOADC || record_en !== 1'b1) begin
      n_err++;
      $display("FAIL zero_start: width %0d record_en %b want %0d 1",
               w, record_en, LOADC);
    end
    release_wait(cyc);
    m_rec = exp_rec(0);
    n_cmp++;
    if (rec_words !== CW'(m_rec)) begin
      n_err++;
      $display("FAIL zero_rec_words: got %0d want %0d", rec_words, m_rec);
    end
    seen = rd_load;
    repeat (10) begin
      tick();
      seen |= rd_load | play_en;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL zero_no_play: got %b want 0", seen);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_abort();
    int n;
    int cyc;
    int w;
    int early;
    n = $urandom_range(4, MAXW - 1);
    press_wait(cyc);
    width(1'b0, w);
    send_we(n);
    release_wait(cyc);
    m_rec = exp_rec(n);
    width(1'b1, w);
    send_rd(3, early);
    n_cmp++;
    if (early != 0 || play_en !== 1'b1) begin
      n_err++;
      $display("FAIL abort_mid_play: early %0d play_en %b want 0 1",
               early, play_en);
    end
    press_wait(cyc);
    n_cmp++;
    if (cyc >= 60 || play_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_press: cyc %0d play_en %b want <60 0", cyc, play_en);
    end
    width(1'b0, w);
    n_cmp++;
    if (w != LOADC || record_en !== 1'b1) begin
      n_err++;
      $display("FAIL abort_rerecord: width %0d record_en %b want %0d 1",
               w, record_en, LOADC);
    end
    release_wait(cyc);
    m_rec = 0;
    n_cmp++;
    if (rec_words !== CW'(m_rec)) begin
      n_err++;
      $display("FAIL abort_rec_words: got %0d want %0d", rec_words, m_rec);
    end
    tick(3);
  endtask

  task automatic test_init_drop();
    int n;
    int cyc;
    int w;
    int early;
    n = $urandom_range(3, MAXW - 1);
    press_wait(cyc);
    width(1'b0, w);
    send_we(n);
    release_wait(cyc);
    m_rec = exp_rec(n);
    width(1'b1, w);
    send_rd(1, early);
    ddr_init_done = 1'b0;
    tick();
    n_cmp++;
    if ({record_en, play_en, wr_load, rd_load, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL drop_play_outs: got %b want 00000",
               {record_en, play_en, wr_load, rd_load, busy});
    end
    n_cmp++;
    if (rec_words !== CW'(m_rec)) begin
      n_err++;
      $display("FAIL drop_play_kept: got %0d want %0d", rec_words, m_rec);
    end
    ddr_init_done = 1'b1;
    tick(2);
    press_wait(cyc);
    width(1'b0, w);
    send_we(2);
    ddr_init_done = 1'b0;
    tick();
    n_cmp++;
    if (record_en !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_rec_outs: record_en %b busy %b want 0 0",
               record_en, busy);
    end
    n_cmp++;
    if (rec_words !== CW'(m_rec)) begin
      n_err++;
      $display("FAIL drop_rec_kept: got %0d want %0d", rec_words, m_rec);
    end
    key1 = 1'b1;
    tick(20);
    ddr_init_done = 1'b1;
    tick(3);
    n_cmp++;
    if (busy !== 1'b0 || wr_load !== 1'b0) begin
      n_err++;
      $display("FAIL drop_recover: busy %b wr_load %b want 0 0", busy, wr_load);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_and_press();
    test_record_play();
    test_limit();
    test_zero_words();
    test_abort();
    test_init_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
Record/playback sequencer for the audio loop-back path. It sits between the board key and the audio/DDR datapath (WAV codec interface and DDR two-FIFO bridge).
- Debounces key1 and runs the record-then-play state machine.
- Issues the DDR FIFO address-reset pulses (wr_load/rd_load).
- Counts the words stored so that playback stops after exactly the recorded length.

Parameters:
DEB_CYCLES, 1000000, stable-level cycles for a debounced key change (20 ms at 50 MHz)
LOAD_CYC, 16, width in clk cycles of the wr_load/rd_load pulses
MAX_WORDS, 480000, recording word limit (10 s of 48 kHz stereo, one 32-bit word per frame)
CNT_W, 24, width of the word counters; must satisfy MAX_WORDS < 2**CNT_W

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  synchronous active-low reset
key1  input  1  raw key, low = pressed, asynchronous
ddr_init_done  input  1  DDR calibration complete
sys_we  input  1  one-cycle write strobe into DDR write FIFO (from codec side)
sys_rd  input  1  one-cycle read strobe from DDR read FIFO (from codec side)
record_en  output  1  codec capture enable
play_en  output  1  codec playback enable
wr_load  output  1  DDR write-address reset pulse
rd_load  output  1  DDR read-address reset pulse
rec_words  output  CNT_W  words captured in the last recording
busy  output  1  high in any state other than IDLE or WAIT_INIT

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low, sampled on the rising edge of clk.
- Reset: all outputs 0, rec_words 0, state WAIT_INIT, debounced key = 1 (released).
- Key input path:
  - key1 passes through a 2-FF synchronizer, then the debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any agreement resets the counter.
  - press = debounced 1->0 event; release = debounced 0->1 event; each is a one-cycle internal strobe.
- State machine, all outputs registered:
  - WAIT_INIT: all outputs 0. Goes to IDLE when ddr_init_done=1.
  - IDLE: press -> REC_LOAD.
  - REC_LOAD: wr_load=1 for exactly LOAD_CYC cycles; word counter cleared on entry. Then -> RECORD.
  - RECORD:
    - record_en=1; each sys_we increments the word counter.
    - Exit on release, or when the counter reaches MAX_WORDS (further sys_we ignored).
    - On exit, latch counter into rec_words. If rec_words = 0 -> IDLE, otherwise -> PLAY_LOAD.
  - PLAY_LOAD: rd_load=1 for LOAD_CYC cycles; play counter cleared. Then -> PLAY.
  - PLAY:
    - play_en=1; each sys_rd increments the play counter.
    - When play counter = rec_words: play_en drops on the next edge, state -> IDLE.
    - Press during PLAY aborts to REC_LOAD.
- Latency: press strobe to wr_load high is 1 cycle. record_en rises on the first RECORD cycle, i.e. LOAD_CYC cycles after wr_load rises.
- sys_we outside RECORD and sys_rd outside PLAY are ignored.
- ddr_init_done falling in any state:
  - next cycle state = WAIT_INIT, record_en/play_en/loads forced 0.
  - rec_words is retained.
- Release arriving in the same cycle as the MAX_WORDS limit: single exit, no double transition.
- Press during REC_LOAD/PLAY_LOAD is ignored.
- A key still held after a limit-terminated recording produces no new recording until it is released and pressed again.
- Counters never wrap; the MAX_WORDS limit guarantees this.

Optional Feature:
LOOP_PLAY_EN
- Defined: on PLAY completion the state goes to PLAY_LOAD instead of IDLE, so playback repeats indefinitely until a press (-> REC_LOAD) or loss of ddr_init_done.
- Undefined: single playback, then IDLE.

Test Plan:
Setup for all scenarios: DEB_CYCLES=8, LOAD_CYC=4, MAX_WORDS=16, ddr_init_done=1 after reset.
1. Reset, then ddr_init_done held 0 for 50 cycles, key pressed -> all outputs stay 0, busy=0; after ddr_init_done=1 the state is IDLE and still no outputs.
2. Key glitch low for 5 cycles -> no wr_load. Key low 20 cycles -> wr_load high exactly 4 cycles, then record_en=1.
3. Record with 10 sys_we pulses, release key -> rec_words=10, rd_load 4 cycles, play_en=1; after 10 sys_rd pulses play_en=0 next cycle, busy=0.
4. Hold key, 20 sys_we pulses -> record_en drops after 16th, rec_words=16, playback of 16 words; key still held produces no new wr_load.
5. Press and release with zero sys_we -> rec_words=0, no rd_load, back to IDLE.
6. Press during PLAY after 3 sys_rd -> wr_load pulse, play_en=0. With LOOP_PLAY_EN defined and no press, a second rd_load follows completion of playback.
